// File: rtl/ft_rx_if.sv
// Byte-stream and FT bus signals of the FT2232H sync-245 receive path.
// master = ft_rx itself, slave = pads/arbiter/consumer side.
interface ft_rx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] ft_data_i;
  logic          ft_rxf;
  logic          ft_oe;
  logic          ft_rd;
  logic          bus_req;
  logic          bus_gnt;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    input  ft_data_i, ft_rxf, bus_gnt, ready_i,
    output ft_oe, ft_rd, bus_req, data_o, valid_o
  );

  modport slave (
    output ft_data_i, ft_rxf, bus_gnt, ready_i,
    input  ft_oe, ft_rd, bus_req, data_o, valid_o
  );
endinterface

// File: rtl/ft_rx.sv
// FT2232H sync-245 RX drain: arbitrated burst reads from the FT RX FIFO
// into a small first-word-fall-through skid FIFO with valid/ready output.
module ft_rx #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  ft_rx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SPACE_MAX = (AW+1)'(DEPTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_OE, S_READ, S_END} state_t;

  state_t        state_q, state_d;
  logic          oe_q, oe_d;
  logic          rd_q, rd_d;
  logic          req_q, req_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic push, pop, valid, space_ok, go;

  // ft_rd is registered, so the strobe seen by the FT this cycle is rd_q.
  assign push     = !rd_q && !bus.ft_rxf;
  assign valid    = (cnt_q != '0);
  assign pop      = valid && bus.ready_i;
  assign space_ok = (cnt_d <= SPACE_MAX);
  assign go       = !bus.ft_rxf && space_ok && bus.bus_gnt;

  always_comb begin
    cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wptr_d = wptr_q + {{(AW-1){1'b0}}, push};
    rptr_d = rptr_q + {{(AW-1){1'b0}}, pop};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!bus.ft_rxf && space_ok) state_d = S_REQ;
      S_REQ: begin
        if (bus.bus_gnt)     state_d = S_OE;
        else if (bus.ft_rxf) state_d = S_IDLE;
      end
      S_OE:   state_d = go ? S_READ : S_END;
      S_READ: state_d = go ? S_READ : S_END;
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Pin levels are a pure function of the next state, then registered.
    req_d = (state_d != S_IDLE);
    oe_d  = !(state_d == S_OE || state_d == S_READ || state_d == S_END);
    rd_d  = (state_d != S_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      oe_q    <= 1'b1;
      rd_q    <= 1'b1;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.ft_data_i;
  end

  assign bus.ft_oe   = oe_q;
  assign bus.ft_rd   = rd_q;
  assign bus.bus_req = req_q;
  assign bus.valid_o = valid;
  assign bus.data_o  = valid ? mem_q[rptr_q] : '0;
endmodule

// File: tb/tb_ft_rx.sv
// Directed bench for ft_rx: FT host model, in-order scoreboard, pin-level sequence checks.
module tb_ft_rx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ft_rx_if #(.DW(8)) bus ();
  ft_rx #(.DW(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  logic [7:0] host_mem [256];
  int host_len = 0, host_idx = 0, out_idx = 0, ncap = 0;
  int run = 0, max_run = 0, bursts = 0, max_occ = 0;
  bit toggle = 1'b0, force_hi = 1'b0;
  logic prev_rd = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_host();
    bus.ft_rxf    = (host_idx >= host_len) || force_hi;
    bus.ft_data_i = (host_idx < 256) ? host_mem[host_idx] : 8'h00;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < 256; i++) host_mem[i] = base + 8'(i);
    host_len = n; host_idx = 0; out_idx = 0; ncap = 0;
    run = 0; max_run = 0; bursts = 0; max_occ = 0; force_hi = 1'b0;
    drive_host();
  endtask

  // One clock: sample pre-edge pins, advance host and scoreboard #1 after the edge.
  task automatic tick();
    bit cap, popd;
    logic [7:0] d;
    int occ;
    cap  = (bus.ft_rd === 1'b0) && (bus.ft_rxf === 1'b0);
    popd = (bus.valid_o === 1'b1) && (bus.ready_i === 1'b1);
    d    = bus.data_o;
    @(posedge clk); #1;
    if (cap) begin
      host_idx++; ncap++; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (popd) begin
      chk("order", {24'h0, d}, (out_idx < host_len) ? {24'h0, host_mem[out_idx]} : 32'hFFFF_FFFF);
      out_idx++;
    end
    occ = ncap - out_idx;
    if (occ > max_occ) max_occ = occ;
    if (prev_rd === 1'b1 && bus.ft_rd === 1'b0) bursts++;
    prev_rd = bus.ft_rd;
    // Toggle mode: rxf goes high for the edge right after every capture.
    if (toggle) force_hi = cap;
    drive_host();
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && out_idx < n; i++) tick();
  endtask

  function automatic logic [2:0] pins();
    return {bus.bus_req, bus.ft_oe, bus.ft_rd};
  endfunction

  initial begin
    int rcnt;
    logic rd_before;
    rst = 1'b1;
    bus.bus_gnt = 1'b1;
    bus.ready_i = 1'b1;
    load(0, 8'h00);
    #1;
    chk("rst_pins", {29'h0, pins()}, 32'h3);
    chk("rst_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("rst_data", {24'h0, bus.data_o}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single byte 0xA5: REQ, OE, READ, END, IDLE.
    load(1, 8'hA5);
    tick(); chk("t2_req",  {29'h0, pins()}, 32'h7);
    tick(); chk("t2_oe",   {29'h0, pins()}, 32'h5);
    tick(); chk("t2_read", {29'h0, pins()}, 32'h4);
    tick();
    chk("t2_valid", {31'h0, bus.valid_o}, 32'h1);
    chk("t2_data", {24'h0, bus.data_o}, 32'hA5);
    tick();
    chk("t2_end", {29'h0, pins()}, 32'h5);
    chk("t2_valid_drop", {31'h0, bus.valid_o}, 32'h0);
    tick(); chk("t2_idle", {29'h0, pins()}, 32'h3);
    chk("t2_ncap", ncap, 1);
    chk("t2_nout", out_idx, 1);

    // Asynchronous reset in the middle of a burst.
    load(20, 8'h10);
    for (int i = 0; i < 10 && bus.ft_rd !== 1'b0; i++) tick();
    tick();
    rd_before = bus.ft_rd;
    chk("t1_mid_burst", {31'h0, rd_before}, 32'h0);
    rst = 1'b1;
    #1;
    chk("t1_rst_pins", {29'h0, pins()}, 32'h3);
    chk("t1_rst_valid", {31'h0, bus.valid_o}, 32'h0);
    load(0, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("t1_empty", {31'h0, bus.valid_o}, 32'h0);
    chk("t1_idle", {29'h0, pins()}, 32'h3);

    // Streaming 0x00..0xFF.
    load(256, 8'h00);
    run_until(256, 400);
    chk("t3_nout", out_idx, 256);
    chk("t3_ncap", ncap, 256);
    chk("t3_run", max_run, 256);
    chk("t3_bursts", bursts, 1);
    repeat (2) tick();
    chk("t3_drained", {31'h0, bus.valid_o}, 32'h0);

    // Backpressure: 10 bytes, consumer stalled.
    bus.ready_i = 1'b0;
    load(10, 8'h30);
    repeat (12) tick();
    chk("t4_ncap_stall", ncap, 3);
    chk("t4_pins_stall", {29'h0, pins()}, 32'h3);
    chk("t4_head", {24'h0, bus.data_o}, 32'h30);
    chk("t4_occ_stall", {31'h0, (max_occ <= 4)}, 32'h1);
    bus.ready_i = 1'b1;
    run_until(10, 200);
    chk("t4_nout", out_idx, 10);
    chk("t4_bursts", bursts, 2);
    chk("t4_occ", {31'h0, (max_occ <= 4)}, 32'h1);

    // Grant loss on the 3rd READ cycle of a 6-byte transfer.
    load(6, 8'h60);
    rcnt = 0;
    for (int i = 0; i < 20 && rcnt < 3; i++) begin
      tick();
      if (bus.ft_rd === 1'b0) rcnt++;
    end
    chk("t5_reads", rcnt, 3);
    bus.bus_gnt = 1'b0;
    tick();
    chk("t5_end", {29'h0, pins()}, 32'h5);
    chk("t5_ncap_abort", ncap, 3);
    tick();
    chk("t5_idle", {29'h0, pins()}, 32'h3);
    bus.bus_gnt = 1'b1;
    run_until(6, 100);
    chk("t5_nout", out_idx, 6);
    chk("t5_ncap", ncap, 6);

    // ft_rxf high every 2nd cycle inside bursts.
    toggle = 1'b1;
    load(8, 8'h90);
    run_until(8, 200);
    chk("t6_nout", out_idx, 8);
    chk("t6_ncap", ncap, 8);
    chk("t6_bursts", bursts, 8);
    toggle = 1'b0;
    force_hi = 1'b0;
    drive_host();
    repeat (3) tick();
    chk("t6_no_extra", {31'h0, bus.valid_o}, 32'h0);
    chk("t6_idle", {29'h0, pins()}, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
